// File: rtl/mac_neuron_scheduler_pkg.sv
// rtl/mac_neuron_scheduler_pkg.sv - Q-format constants, scheduler state enum and saturation helper
package mac_neuron_scheduler_pkg;

  localparam int FRAC_BITS = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MAC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Clamp a sign-extended value to the range of a vw-bit signed word.
  function automatic logic signed [31:0] sat_s32(input logic signed [31:0] t, input int vw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (vw - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (t > hi) begin
      return hi;
    end else if (t < lo) begin
      return lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/mac_neuron_scheduler_lif_update.sv
// rtl/mac_neuron_scheduler_lif_update.sv - combinational leaky integrate-and-fire membrane update
module mac_neuron_scheduler_lif_update
  import mac_neuron_scheduler_pkg::*;
#(
  parameter int W_BITS = 8,
  parameter int V_W    = 16,
  parameter int THRESH = 1 << FRAC_BITS,
  parameter int LEAK   = 4
) (
  input  logic signed [V_W-1:0]    v_in,
  input  logic signed [W_BITS-1:0] sum_in,
  output logic signed [V_W-1:0]    v_out,
  output logic                     spike
);

  localparam logic signed [V_W+1:0] LEAK_X   = (V_W + 2)'(LEAK);
  localparam logic signed [V_W-1:0] THRESH_X = V_W'(THRESH);

  logic signed [V_W+1:0] t;
  logic signed [31:0]    t32;
  logic signed [V_W-1:0] v_sat;

  // Two guard bits keep v - LEAK + s exact before the clamp.
  always_comb begin
    t     = {{2{v_in[V_W-1]}}, v_in} - LEAK_X
          + {{(V_W + 2 - W_BITS){sum_in[W_BITS-1]}}, sum_in};
    t32   = {{(32 - V_W - 2){t[V_W+1]}}, t};
    v_sat = V_W'(sat_s32(t32, V_W));
    spike = (v_sat >= THRESH_X);
    v_out = spike ? '0 : v_sat;
  end

endmodule

// File: rtl/mac_neuron_scheduler.sv
// rtl/mac_neuron_scheduler.sv - time-multiplexes one external 25-input MAC over a row of LIF neurons
module mac_neuron_scheduler
  import mac_neuron_scheduler_pkg::*;
#(
  parameter int NUM_IN      = 25,
  parameter int W_BITS      = 8,
  parameter int NUM_NEURONS = 10,
  parameter int V_W         = 16,
  parameter int THRESH      = 1 << FRAC_BITS,
  parameter int LEAK        = 4,
  localparam int K_W        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN-1:0]        in_pix,
  input  logic                     clear_v,
  output logic                     wt_en,
  output logic [K_W-1:0]           wt_addr,
  input  logic [NUM_IN*W_BITS-1:0] wt_rdata,
  output logic [NUM_IN-1:0]        mac_p,
  output logic [NUM_IN*W_BITS-1:0] mac_w,
  input  logic [W_BITS-1:0]        mac_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_NEURONS-1:0]   out_spk,
  output logic                     busy
);

  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_NEURONS - 1);

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [NUM_IN-1:0]     pix_q, pix_d;
  logic [NUM_NEURONS-1:0] spk_q, spk_d;
  logic signed [V_W-1:0] v_q [NUM_NEURONS];
  logic signed [V_W-1:0] v_d [NUM_NEURONS];

  logic signed [V_W-1:0] lif_v;
  logic                  lif_spike;

  mac_neuron_scheduler_lif_update #(
    .W_BITS (W_BITS),
    .V_W    (V_W),
    .THRESH (THRESH),
    .LEAK   (LEAK)
  ) u_lif (
    .v_in   (v_q[k_q]),
    .sum_in (mac_sum),
    .v_out  (lif_v),
    .spike  (lif_spike)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pix_d   = pix_q;
    spk_d   = spk_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        // Clear first so a frame accepted in the same cycle integrates from zero.
        if (clear_v) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            v_d[i] = '0;
          end
        end
        if (in_valid) begin
          pix_d   = in_pix;
          spk_d   = '0;
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        state_d = MAC;
      end
      MAC: begin
        v_d[k_q] = lif_v;
        if (lif_spike) begin
          spk_d[k_q] = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = READ;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      pix_q   <= '0;
      spk_q   <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pix_q   <= pix_d;
      spk_q   <= spk_d;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i] <= v_d[i];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wt_en     = (state_q == READ);
  assign wt_addr   = k_q;
  assign mac_p     = pix_q;
  assign mac_w     = wt_rdata;
  assign out_valid = (state_q == DONE);
  assign out_spk   = spk_q;

endmodule
